// File: rtl/mcp47feb_dac_writer.sv
// Command sequencer for i2c_master: turns one (channel, value) request into a
// single write-multiple transaction to an MCP47FEB dual 12-bit DAC.
module mcp47feb_dac_writer #(
    parameter logic [6:0] DEV_ADDR = 7'h60,
    parameter int         TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_channel,
    input  logic [11:0] s_value,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  data_in,
    output logic        data_in_valid,
    input  logic        data_in_ready,
    output logic        data_in_last,
    input  logic        i2c_busy,
    input  logic        missed_ack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        nack_seen
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_D0   = 3'd2,
        ST_D1   = 3'd3,
        ST_D2   = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state_r;
    logic [15:0] timer_r;
    logic        channel_r;
    logic [11:0] value_r;
    logic        s_ready_r;
    logic        busy_r;
    logic        cmd_valid_r;
    logic        cmd_wm_r;
    logic        cmd_stop_r;
    logic [7:0]  data_r;
    logic        data_valid_r;
    logic        data_last_r;
    logic        done_r;
    logic        error_r;
    logic        nack_seen_r;
    logic        advance_s;

    assign cmd_address        = DEV_ADDR;
    assign cmd_start          = 1'b0;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;
    assign s_ready            = s_ready_r;
    assign busy               = busy_r;
    assign cmd_valid          = cmd_valid_r;
    assign cmd_write_multiple = cmd_wm_r;
    assign cmd_stop           = cmd_stop_r;
    assign data_in            = data_r;
    assign data_in_valid      = data_valid_r;
    assign data_in_last       = data_last_r;
    assign done               = done_r;
    assign error              = error_r;
    assign nack_seen          = nack_seen_r;

    // Condition that lets the current non-idle state move on this cycle
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            ST_CMD:                advance_s = cmd_ready;
            ST_D0, ST_D1, ST_D2:   advance_s = data_in_ready;
            ST_WAIT:               advance_s = ~i2c_busy;
            default:               advance_s = 1'b0;
        endcase
    end

    // Sequencer state, timeout counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            timer_r      <= 16'd0;
            channel_r    <= 1'b0;
            value_r      <= 12'd0;
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            cmd_valid_r  <= 1'b0;
            cmd_wm_r     <= 1'b0;
            cmd_stop_r   <= 1'b0;
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            data_last_r  <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            nack_seen_r  <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                s_ready_r <= 1'b1;
                busy_r    <= 1'b0;
                if (s_valid && s_ready_r) begin
                    channel_r   <= s_channel;
                    value_r     <= s_value;
                    nack_seen_r <= 1'b0;
                    timer_r     <= 16'd0;
                    state_r     <= ST_CMD;
                    s_ready_r   <= 1'b0;
                    busy_r      <= 1'b1;
                    cmd_valid_r <= 1'b1;
                    cmd_wm_r    <= 1'b1;
                    cmd_stop_r  <= 1'b1;
                end
            end else begin
                if (missed_ack) begin
                    nack_seen_r <= 1'b1;
                end
                // A handshake takes priority over an expiring timeout
                if (advance_s) begin
                    timer_r <= 16'd0;
                    case (state_r)
                        ST_CMD: begin
                            state_r      <= ST_D0;
                            cmd_valid_r  <= 1'b0;
                            cmd_wm_r     <= 1'b0;
                            cmd_stop_r   <= 1'b0;
                            data_valid_r <= 1'b1;
                            data_r       <= {4'b0000, channel_r, 3'b000};
                        end
                        ST_D0: begin
                            state_r <= ST_D1;
                            data_r  <= {4'b0000, value_r[11:8]};
                        end
                        ST_D1: begin
                            state_r     <= ST_D2;
                            data_r      <= value_r[7:0];
                            data_last_r <= 1'b1;
                        end
                        ST_D2: begin
                            state_r      <= ST_WAIT;
                            data_valid_r <= 1'b0;
                            data_last_r  <= 1'b0;
                            data_r       <= 8'h00;
                        end
                        ST_WAIT: begin
                            state_r   <= ST_IDLE;
                            busy_r    <= 1'b0;
                            s_ready_r <= 1'b1;
                            if (nack_seen_r || missed_ack) begin
                                error_r <= 1'b1;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                        end
                    endcase
                end else if (timer_r == TIMEOUT_LAST) begin
                    state_r      <= ST_IDLE;
                    timer_r      <= 16'd0;
                    cmd_valid_r  <= 1'b0;
                    cmd_wm_r     <= 1'b0;
                    cmd_stop_r   <= 1'b0;
                    data_valid_r <= 1'b0;
                    data_last_r  <= 1'b0;
                    data_r       <= 8'h00;
                    nack_seen_r  <= 1'b1;
                    error_r      <= 1'b1;
                    busy_r       <= 1'b0;
                    s_ready_r    <= 1'b1;
                end else begin
                    timer_r <= timer_r + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcp47feb_dac_writer.sv
// Directed bench for mcp47feb_dac_writer: vector table driven through an ideal
// i2c_master model, plus timeout and mid-transaction reset sequences.
module tb_mcp47feb_dac_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic        s_channel;
    logic [11:0] s_value;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        data_in_last;
    logic        i2c_busy;
    logic        missed_ack;
    logic        busy, done, error, nack_seen;

    always #5 clk = ~clk;

    mcp47feb_dac_writer #(.DEV_ADDR(7'h60), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_channel(s_channel), .s_value(s_value),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_in_last(data_in_last), .i2c_busy(i2c_busy), .missed_ack(missed_ack),
        .busy(busy), .done(done), .error(error), .nack_seen(nack_seen)
    );

    typedef struct {
        logic        ch;
        logic [11:0] val;
        int          stall_byte;
        int          stall_cycles;
        bit          nack;
        logic [7:0]  e0, e1, e2;
        bit          exp_err;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check({tag, "_cmd_wm"}, 32'(cmd_write_multiple), 32'd0);
        check({tag, "_cmd_stop"}, 32'(cmd_stop), 32'd0);
        check({tag, "_data_valid"}, 32'(data_in_valid), 32'd0);
        check({tag, "_data_last"}, 32'(data_in_last), 32'd0);
        check({tag, "_data_in"}, 32'(data_in), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_nack_seen"}, 32'(nack_seen), 32'd0);
        check({tag, "_cmd_address"}, 32'(cmd_address), 32'h60);
    endtask

    // Issue one request and act as an ideal i2c_master until done/error appears.
    task automatic run_txn(input vec_t v, input string tag);
        logic [7:0] cap_b[4];
        logic       cap_l[4];
        int         n_cmd = 0, n_bytes = 0, n_done = 0, n_err = 0;
        int         stall_cnt = 0, busy_tail = 0, term_wait = -1;
        logic [7:0] stall_val = 8'h00;
        logic [6:0] cmd_addr_seen = 7'h00;
        logic       wm_seen = 1'b0, stop_seen = 1'b0;
        bit         nack_fired = 1'b0, stable_bad = 1'b0, ready_bad = 1'b0, term_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cap_b[i] = 8'h00;
            cap_l[i] = 1'b0;
        end
        check({tag, "_idle_ready"}, 32'(s_ready), 32'd1);
        s_valid   = 1'b1;
        s_channel = v.ch;
        s_value   = v.val;
        @(negedge clk);
        s_valid = 1'b0;
        check({tag, "_cmd_latency"}, 32'(cmd_valid), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nack_clear"}, 32'(nack_seen), 32'd0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) n_done++;
            if (error) n_err++;
            if ((done || error) && !s_ready) ready_bad = 1'b1;
            if ((done || error) && term_wait < 0) begin
                term_wait = 3;
                term_seen = 1'b1;
            end
            if (term_wait == 0) break;
            if (term_wait > 0) term_wait--;
            cmd_ready = cmd_valid;
            if (cmd_valid) begin
                n_cmd++;
                cmd_addr_seen = cmd_address;
                wm_seen       = cmd_write_multiple;
                stop_seen     = cmd_stop;
            end
            missed_ack = 1'b0;
            if (v.nack && !nack_fired && n_bytes >= 1) begin
                missed_ack = 1'b1;
                nack_fired = 1'b1;
            end
            if (n_bytes == 3) busy_tail++;
            data_in_ready = 1'b0;
            if (data_in_valid) begin
                if (n_bytes == v.stall_byte && stall_cnt > 0 && data_in != stall_val)
                    stable_bad = 1'b1;
                if (n_bytes == v.stall_byte && stall_cnt < v.stall_cycles) begin
                    stall_val = data_in;
                    stall_cnt++;
                end else begin
                    data_in_ready = 1'b1;
                    if (n_bytes < 4) begin
                        cap_b[n_bytes] = data_in;
                        cap_l[n_bytes] = data_in_last;
                    end
                    n_bytes++;
                end
            end
            i2c_busy = (n_cmd > 0) && (busy_tail < 4);
            @(negedge clk);
        end
        cmd_ready = 1'b0; data_in_ready = 1'b0; missed_ack = 1'b0; i2c_busy = 1'b0;
        check({tag, "_terminated"}, 32'(term_seen), 32'd1);
        check({tag, "_n_cmd"}, 32'(n_cmd), 32'd1);
        check({tag, "_cmd_addr"}, 32'(cmd_addr_seen), 32'h60);
        check({tag, "_cmd_wm_stop"}, {30'd0, wm_seen, stop_seen}, 32'd3);
        check({tag, "_n_bytes"}, 32'(n_bytes), 32'd3);
        check({tag, "_byte0"}, 32'(cap_b[0]), 32'(v.e0));
        check({tag, "_byte1"}, 32'(cap_b[1]), 32'(v.e1));
        check({tag, "_byte2"}, 32'(cap_b[2]), 32'(v.e2));
        check({tag, "_last_flags"}, {29'd0, cap_l[0], cap_l[1], cap_l[2]}, 32'd1);
        check({tag, "_n_done"}, 32'(n_done), v.exp_err ? 32'd0 : 32'd1);
        check({tag, "_n_error"}, 32'(n_err), v.exp_err ? 32'd1 : 32'd0);
        check({tag, "_ready_at_end"}, 32'(ready_bad), 32'd0);
        check({tag, "_data_stable"}, 32'(stable_bad), 32'd0);
        check({tag, "_nack_sticky"}, 32'(nack_seen), 32'(v.exp_err));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cv_cycles;
        vecs[0] = '{1'b0, 12'hABC, -1, 0, 1'b0, 8'h00, 8'h0A, 8'hBC, 1'b0};
        vecs[1] = '{1'b1, 12'h3FF, -1, 0, 1'b0, 8'h08, 8'h03, 8'hFF, 1'b0};
        vecs[2] = '{1'b0, 12'hABC,  1, 10, 1'b0, 8'h00, 8'h0A, 8'hBC, 1'b0};
        vecs[3] = '{1'b1, 12'h5A5, -1, 0, 1'b1, 8'h08, 8'h05, 8'hA5, 1'b1};
        vecs[4] = '{1'b0, 12'h123, -1, 0, 1'b0, 8'h00, 8'h01, 8'h23, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_channel = 1'b0; s_value = 12'h000;
        cmd_ready = 1'b0; data_in_ready = 1'b0; i2c_busy = 1'b0; missed_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_ready_rise", 32'(s_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // cmd_ready held low: abort after 16 cycles of cmd_valid
        s_valid = 1'b1; s_channel = 1'b0; s_value = 12'h777;
        @(negedge clk);
        s_valid = 1'b0;
        cv_cycles = 0;
        for (int c = 0; c < 100 && cmd_valid; c++) begin
            cv_cycles++;
            @(negedge clk);
        end
        check("to_cmd_valid_cycles", 32'(cv_cycles), 32'd16);
        check("to_cmd_valid_drop", 32'(cmd_valid), 32'd0);
        check("to_error", 32'(error), 32'd1);
        check("to_s_ready", 32'(s_ready), 32'd1);
        check("to_nack_seen", 32'(nack_seen), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_error_pulse", 32'(error), 32'd0);

        // Reset asserted while the DAC code high byte is on offer
        s_valid = 1'b1; s_channel = 1'b0; s_value = 12'hABC;
        @(negedge clk);
        s_valid = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("rs_d0_byte", 32'(data_in), 32'h00);
        data_in_ready = 1'b1;
        @(negedge clk);
        data_in_ready = 1'b0;
        check("rs_d1_byte", 32'(data_in), 32'h0A);
        check("rs_d1_valid", 32'(data_in_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_rise", 32'(s_ready), 32'd1);
        run_txn(vecs[1], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
